// File: rtl/bresenham_line_drawer.sv
// Bresenham line rasteriser: latches endpoints on i_go and emits one pixel per
// clock in DRAW, gating the plot strobe to the visible window.
module bresenham_line_drawer #(
  parameter int H_RES = 320,
  parameter int V_RES = 240
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic       i_go,
  input  logic [2:0] i_colour,
  input  logic [8:0] i_X0,
  input  logic [8:0] i_X1,
  input  logic [7:0] i_Y0,
  input  logic [7:0] i_Y1,
  output logic       o_done,
  output logic       o_plot,
  output logic [8:0] o_x,
  output logic [7:0] o_y,
  output logic [2:0] o_colour
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_DRAW = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [9:0] H_LIM = 10'(H_RES);
  localparam logic [8:0] V_LIM = 9'(V_RES);

  logic [1:0] state;

  logic [8:0] x0, x1, cur_x;
  logic [7:0] y0, y1, cur_y;
  logic [2:0] colour;
  logic       sx_neg, sy_neg;

  logic signed [11:0] dx, dy, err;

  logic signed [11:0] adx, ady;
  logic signed [11:0] e2, err_nx;
  logic               step_x, step_y, at_end;

  function automatic logic signed [11:0] abs_diff(input logic [8:0] a, input logic [8:0] b);
    logic signed [11:0] d;
    d = $signed({3'b000, a}) - $signed({3'b000, b});
    return (d < 12'sd0) ? -d : d;
  endfunction

  // Error-term step: both axis corrections are evaluated against the same e2
  // and folded into one new err value.
  always_comb begin
    adx    = abs_diff(x0, x1);
    ady    = abs_diff({1'b0, y0}, {1'b0, y1});
    e2     = err <<< 1;
    step_x = (e2 >= dy);
    step_y = (e2 <= dx);
    err_nx = err + (step_x ? dy : 12'sd0) + (step_y ? dx : 12'sd0);
    at_end = (cur_x == x1) && (cur_y == y1);
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state  <= S_IDLE;
      x0     <= '0;
      x1     <= '0;
      y0     <= '0;
      y1     <= '0;
      colour <= '0;
      cur_x  <= '0;
      cur_y  <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_go) begin
            x0     <= i_X0;
            x1     <= i_X1;
            y0     <= i_Y0;
            y1     <= i_Y1;
            colour <= i_colour;
            state  <= S_INIT;
          end
        end
        S_INIT: begin
          dx     <= adx;
          dy     <= -ady;
          err    <= adx - ady;
          sx_neg <= !(x0 < x1);
          sy_neg <= !(y0 < y1);
          cur_x  <= x0;
          cur_y  <= y0;
          state  <= S_DRAW;
        end
        S_DRAW: begin
          if (at_end) begin
            state <= S_DONE;
          end else begin
            err <= err_nx;
            if (step_x) cur_x <= sx_neg ? cur_x - 9'd1 : cur_x + 9'd1;
            if (step_y) cur_y <= sy_neg ? cur_y - 8'd1 : cur_y + 8'd1;
          end
        end
        default: begin
          if (!i_go) state <= S_IDLE;
        end
      endcase
    end
  end

  // Off-screen pixels still advance the walk but never strobe the frame buffer.
  assign o_plot   = (state == S_DRAW) && ({1'b0, cur_x} < H_LIM) && ({1'b0, cur_y} < V_LIM);
  assign o_done   = (state == S_DONE);
  assign o_x      = cur_x;
  assign o_y      = cur_y;
  assign o_colour = colour;

endmodule

// File: tb/tb_bresenham_line_drawer.sv
// Directed bench for bresenham_line_drawer: each scenario task drives one line
// and compares plotted pixels, latency and handshake against hand-worked values.
module tb_bresenham_line_drawer;

  logic       clock;
  logic       i_reset;
  logic       i_go;
  logic [2:0] i_colour;
  logic [8:0] i_X0, i_X1;
  logic [7:0] i_Y0, i_Y1;
  logic       o_done, o_plot;
  logic [8:0] o_x;
  logic [7:0] o_y;
  logic [2:0] o_colour;

  int checks = 0;
  int passes = 0;

  int px[$];
  int py[$];
  int pc[$];

  bresenham_line_drawer #(.H_RES(320), .V_RES(240)) dut (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_go     (i_go),
    .i_colour (i_colour),
    .i_X0     (i_X0),
    .i_X1     (i_X1),
    .i_Y0     (i_Y0),
    .i_Y1     (i_Y1),
    .o_done   (o_done),
    .o_plot   (o_plot),
    .o_x      (o_x),
    .o_y      (o_y),
    .o_colour (o_colour)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives one line request, scrambles the inputs right after go is sampled,
  // and records every strobed pixel. lat = edges from the sampling edge
  // (counted as 1) until o_done is seen; 0 if the budget expires.
  task automatic run_line(input logic [8:0] x0, input logic [7:0] y0,
                          input logic [8:0] x1, input logic [7:0] y1,
                          input logic [2:0] col, output int lat);
    px.delete(); py.delete(); pc.delete();
    lat = 0;
    @(negedge clock);
    i_X0 = x0; i_Y0 = y0; i_X1 = x1; i_Y1 = y1; i_colour = col; i_go = 1'b1;
    @(posedge clock);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clock);
      if (k == 1) begin
        i_X0 = 9'h1AA; i_X1 = 9'h055; i_Y0 = 8'hC3; i_Y1 = 8'h3C; i_colour = ~col;
      end
      if (o_plot) begin
        px.push_back(int'(o_x)); py.push_back(int'(o_y)); pc.push_back(int'(o_colour));
      end
      if (o_done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic end_line();
    @(negedge clock);
    i_go = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_go = 1'b0; i_colour = 3'd0;
    i_X0 = '0; i_X1 = '0; i_Y0 = '0; i_Y1 = '0;
    repeat (2) @(negedge clock);
    checks++; if (o_done !== 1'b0) $display("FAIL reset_done got %b want 0", o_done); else passes++;
    checks++; if (o_plot !== 1'b0) $display("FAIL reset_plot got %b want 0", o_plot); else passes++;
    checks++; if (o_x !== 9'd0) $display("FAIL reset_x got %0d want 0", o_x); else passes++;
    checks++; if (o_y !== 8'd0) $display("FAIL reset_y got %0d want 0", o_y); else passes++;
    checks++; if (o_colour !== 3'd0) $display("FAIL reset_colour got %0d want 0", o_colour); else passes++;
    i_reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_horizontal();
    int lat;
    run_line(9'd0, 8'd0, 9'd4, 8'd0, 3'b100, lat);
    checks++; if (lat !== 7) $display("FAIL horiz_latency got %0d want 7", lat); else passes++;
    checks++; if (px.size() !== 5) $display("FAIL horiz_count got %0d want 5", px.size()); else passes++;
    for (int i = 0; i < px.size() && i < 5; i++) begin
      checks++;
      if (px[i] !== i || py[i] !== 0 || pc[i] !== 4)
        $display("FAIL horiz_pixel%0d got (%0d,%0d,c%0d) want (%0d,0,c4)", i, px[i], py[i], pc[i], i);
      else passes++;
    end
    @(negedge clock);
    checks++; if (o_done !== 1'b1 || o_plot !== 1'b0)
      $display("FAIL horiz_done_held got done=%b plot=%b want done=1 plot=0", o_done, o_plot); else passes++;
    i_go = 1'b0;
    @(negedge clock);
    checks++; if (o_done !== 1'b0) $display("FAIL horiz_done_drop got %b want 0", o_done); else passes++;
  endtask

  task automatic test_diagonal();
    int lat;
    int ex[4] = '{10, 9, 8, 7};
    run_line(9'd10, 8'd10, 9'd7, 8'd7, 3'b010, lat);
    checks++; if (lat !== 6) $display("FAIL diag_latency got %0d want 6", lat); else passes++;
    checks++; if (px.size() !== 4) $display("FAIL diag_count got %0d want 4", px.size()); else passes++;
    for (int i = 0; i < px.size() && i < 4; i++) begin
      checks++;
      if (px[i] !== ex[i] || py[i] !== ex[i] || pc[i] !== 2)
        $display("FAIL diag_pixel%0d got (%0d,%0d,c%0d) want (%0d,%0d,c2)", i, px[i], py[i], pc[i], ex[i], ex[i]);
      else passes++;
    end
    end_line();
  endtask

  task automatic test_steep();
    int lat;
    int ex[4] = '{0, 0, 1, 1};
    int ey[4] = '{0, 1, 2, 3};
    run_line(9'd0, 8'd0, 9'd1, 8'd3, 3'b001, lat);
    checks++; if (lat !== 6) $display("FAIL steep_latency got %0d want 6", lat); else passes++;
    checks++; if (px.size() !== 4) $display("FAIL steep_count got %0d want 4", px.size()); else passes++;
    for (int i = 0; i < px.size() && i < 4; i++) begin
      checks++;
      if (px[i] !== ex[i] || py[i] !== ey[i])
        $display("FAIL steep_pixel%0d got (%0d,%0d) want (%0d,%0d)", i, px[i], py[i], ex[i], ey[i]);
      else passes++;
    end
    end_line();
  endtask

  task automatic test_single();
    int lat;
    run_line(9'd5, 8'd5, 9'd5, 8'd5, 3'b111, lat);
    checks++; if (lat !== 3) $display("FAIL single_latency got %0d want 3", lat); else passes++;
    checks++; if (px.size() !== 1) $display("FAIL single_count got %0d want 1", px.size()); else passes++;
    if (px.size() >= 1) begin
      checks++;
      if (px[0] !== 5 || py[0] !== 5 || pc[0] !== 7)
        $display("FAIL single_pixel got (%0d,%0d,c%0d) want (5,5,c7)", px[0], py[0], pc[0]);
      else passes++;
    end
    end_line();
  endtask

  task automatic test_offscreen();
    int lat;
    run_line(9'd318, 8'd0, 9'd321, 8'd0, 3'b101, lat);
    checks++; if (lat !== 6) $display("FAIL offscr_latency got %0d want 6 (4 draw cycles)", lat); else passes++;
    checks++; if (px.size() !== 2) $display("FAIL offscr_count got %0d want 2", px.size()); else passes++;
    for (int i = 0; i < px.size() && i < 2; i++) begin
      checks++;
      if (px[i] !== 318 + i || py[i] !== 0)
        $display("FAIL offscr_pixel%0d got (%0d,%0d) want (%0d,0)", i, px[i], py[i], 318 + i);
      else passes++;
    end
    end_line();
  endtask

  task automatic test_reset_mid_draw();
    int plots = 0;
    int lat;
    int stray = 0;
    @(negedge clock);
    i_X0 = 9'd0; i_Y0 = 8'd0; i_X1 = 9'd100; i_Y1 = 8'd0; i_colour = 3'b110; i_go = 1'b1;
    for (int k = 0; k < 200 && plots < 10; k++) begin
      @(negedge clock);
      if (o_plot) plots++;
    end
    checks++; if (plots !== 10) $display("FAIL midrst_plots got %0d want 10", plots); else passes++;
    i_reset = 1'b1; i_go = 1'b0;
    #1;
    checks++; if (o_plot !== 1'b0 || o_done !== 1'b0 || o_x !== 9'd0)
      $display("FAIL midrst_async got plot=%b done=%b x=%0d want 0,0,0", o_plot, o_done, o_x); else passes++;
    @(negedge clock);
    i_reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (o_plot || o_done) stray++;
    end
    checks++; if (stray !== 0) $display("FAIL midrst_idle got %0d active cycles want 0", stray); else passes++;
    run_line(9'd2, 8'd2, 9'd3, 8'd2, 3'b011, lat);
    checks++; if (px.size() !== 2) $display("FAIL midrst_count got %0d want 2", px.size()); else passes++;
    for (int i = 0; i < px.size() && i < 2; i++) begin
      checks++;
      if (px[i] !== 2 + i || py[i] !== 2 || pc[i] !== 3)
        $display("FAIL midrst_pixel%0d got (%0d,%0d,c%0d) want (%0d,2,c3)", i, px[i], py[i], pc[i], 2 + i);
      else passes++;
    end
    end_line();
  endtask

  task automatic test_back_to_back();
    int lat;
    int ex[6] = '{3, 2, 2, 1, 1, 0};
    int ey[6] = '{5, 4, 3, 2, 1, 0};
    run_line(9'd3, 8'd5, 9'd0, 8'd0, 3'b011, lat);
    checks++; if (lat !== 8) $display("FAIL b2b_a_latency got %0d want 8", lat); else passes++;
    checks++; if (px.size() !== 6) $display("FAIL b2b_a_count got %0d want 6", px.size()); else passes++;
    for (int i = 0; i < px.size() && i < 6; i++) begin
      checks++;
      if (px[i] !== ex[i] || py[i] !== ey[i])
        $display("FAIL b2b_a_pixel%0d got (%0d,%0d) want (%0d,%0d)", i, px[i], py[i], ex[i], ey[i]);
      else passes++;
    end
    end_line();
    run_line(9'd1, 8'd1, 9'd3, 8'd1, 3'b001, lat);
    checks++; if (lat !== 5) $display("FAIL b2b_b_latency got %0d want 5", lat); else passes++;
    checks++; if (px.size() !== 3 || (px.size() == 3 && (px[0] !== 1 || px[2] !== 3 || py[1] !== 1)))
      $display("FAIL b2b_b_pixels got count=%0d want 3 pixels (1..3,1)", px.size()); else passes++;
    end_line();
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_diagonal();
    test_steep();
    test_single();
    test_offscreen();
    test_reset_mid_draw();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
